// File: rtl/tic_tac_toe_pkg.sv
// ---------------------------------------------------------------------------
// tic_tac_toe_pkg
// Shared definitions for the tic-tac-toe game engine and its formal checker:
// cell codes, the engine state enum, the table of the eight winning lines and
// a helper that extracts one cell from the packed 18-bit board.
// ---------------------------------------------------------------------------
package tic_tac_toe_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b10;
    localparam cell_t CELL_A     = 2'b01;
    localparam cell_t CELL_B     = 2'b00;

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        WIN   = 2'd2,
        DRAW  = 2'd3
    } state_t;

    // Cell indices of every winning line: rows, columns, then diagonals.
    localparam int WIN_LINES [NUM_LINES][3] = '{
        '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
        '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
        '{0, 4, 8}, '{2, 4, 6}
    };

    // Cell idx lives at bits [2*idx+1:2*idx] of the packed board.
    function automatic cell_t cell_at(input logic [2*NUM_CELLS-1:0] b, input int idx);
        return b[2*idx +: 2];
    endfunction

endpackage

// File: rtl/tic_tac_toe_win_detect.sv
// ---------------------------------------------------------------------------
// tic_tac_toe_win_detect
// Purely combinational: reports whether `player` owns all three cells of any
// of the eight lines in WIN_LINES.
// Ports:
//   board   in  18  packed board, cell i at [2i+1:2i]
//   player  in  2   cell code of the side being tested (CELL_A / CELL_B)
//   win     out 1   1 when player holds a complete line
// ---------------------------------------------------------------------------
module tic_tac_toe_win_detect
    import tic_tac_toe_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] board,
    input  cell_t                  player,
    output logic                   win
);

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        win = 1'b0;
        for (int l = 0; l < NUM_LINES; l++) begin
            if (cell_at(board, WIN_LINES[l][0]) == player &&
                cell_at(board, WIN_LINES[l][1]) == player &&
                cell_at(board, WIN_LINES[l][2]) == player) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tic_tac_toe_game.sv
// ---------------------------------------------------------------------------
// tic_tac_toe_game
// Game engine: takes moves from players A and B, accepts only the in-turn
// player's legal move, keeps the registered 9-cell board, and after each
// accepted move spends one CHECK cycle deciding win / draw / next turn.
// Ports:
//   clk           in   1      clock, all state on posedge
//   reset         in   1      synchronous active-high reset (priority)
//   new_game      in   1      synchronous restart, same effect as reset
//   move_valid_A  in   1      player A presents move_A
//   move_A        in   POS_W  player A target cell
//   move_valid_B  in   1      player B presents move_B
//   move_B        in   POS_W  player B target cell
//   board         out  18     registered board, cell i at [2i+1:2i]
//   turn          out  1      1 = A to move, 0 = B to move
//   move_ready    out  1      high in PLAY only
//   illegal_move  out  1      one-cycle pulse after a rejected in-turn move
//   game_over     out  1      high in WIN / DRAW
//   winner        out  2      01 A, 00 B, 10 none/draw
//   move_count    out  4      accepted moves since reset, 0..9
// ---------------------------------------------------------------------------
module tic_tac_toe_game
    import tic_tac_toe_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b1,
    parameter int POS_W        = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   new_game,
    input  logic                   move_valid_A,
    input  logic [POS_W-1:0]       move_A,
    input  logic                   move_valid_B,
    input  logic [POS_W-1:0]       move_B,
    output logic [2*NUM_CELLS-1:0] board,
    output logic                   turn,
    output logic                   move_ready,
    output logic                   illegal_move,
    output logic                   game_over,
    output logic [1:0]             winner,
    output logic [3:0]             move_count
);

    localparam logic [3:0] FULL_COUNT = 4'(NUM_CELLS);

    state_t                 state_q, state_d;
    logic [2*NUM_CELLS-1:0] board_q, board_d;
    logic                   turn_q;
    logic [3:0]             count_q;
    logic                   illegal_q;

    logic                   restart;
    cell_t                  mover;
    logic                   sel_valid;
    logic [POS_W-1:0]       sel_pos;
    logic                   cell_free;
    logic                   accept;
    logic                   reject;
    logic                   mover_wins;

    assign restart = reset | new_game;

    // Only the side to move is ever looked at; the other side's inputs are
    // dropped without any indication.
    assign mover     = turn_q ? CELL_A : CELL_B;
    assign sel_valid = turn_q ? move_valid_A : move_valid_B;
    assign sel_pos   = turn_q ? move_A : move_B;

    // Positions above 8 match no cell index, so they come out as not free
    // and are rejected exactly like an occupied cell.
    always_comb begin
        cell_free = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (32'(sel_pos) == i && cell_at(board_q, i) == CELL_EMPTY) begin
                cell_free = 1'b1;
            end
        end
    end

    assign accept = (state_q == PLAY) && sel_valid && cell_free;
    assign reject = (state_q == PLAY) && sel_valid && !cell_free;

    always_comb begin
        board_d = board_q;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (accept && 32'(sel_pos) == i) begin
                board_d[2*i +: 2] = mover;
            end
        end
    end

    // In CHECK the board register already holds the mover's new piece and
    // turn_q still names the mover, so one detector instance suffices.
    tic_tac_toe_win_detect u_win_detect (
        .board  (board_q),
        .player (mover),
        .win    (mover_wins)
    );

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (restart) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLAY:    if (accept) state_d = CHECK;
            CHECK: begin
                if (mover_wins)                state_d = WIN;
                else if (count_q == FULL_COUNT) state_d = DRAW;
                else                            state_d = PLAY;
            end
            WIN:     state_d = WIN;
            DRAW:    state_d = DRAW;
            default: state_d = PLAY;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        move_ready = 1'b0;
        game_over  = 1'b0;
        winner     = CELL_EMPTY;
        unique case (state_q)
            PLAY:  move_ready = 1'b1;
            WIN: begin
                game_over = 1'b1;
                winner    = mover;
            end
            DRAW:  game_over = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Datapath: board, turn, counters ----------------
    // NOTE: the board array is reset like any control register because an
    // empty cell is the non-zero code 2'b10, and legality depends on it.
    always_ff @(posedge clk) begin
        if (restart) begin
            board_q   <= {NUM_CELLS{CELL_EMPTY}};
            turn_q    <= FIRST_PLAYER;
            count_q   <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            board_q   <= board_d;
            illegal_q <= reject;
            if (accept && count_q != FULL_COUNT) begin
                count_q <= count_q + 4'd1;
            end
            if (state_q == CHECK && state_d == PLAY) begin
                turn_q <= ~turn_q;
            end
        end
    end

    assign board        = board_q;
    assign turn         = turn_q;
    assign illegal_move = illegal_q;
    assign move_count   = count_q;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// ---------------------------------------------------------------------------
// tb_tic_tac_toe_game
// Drives two engines (A first, B first) with the same stimulus and compares
// every output of both against a rule-level game model each cycle, plus
// hand-computed expectations on directed games.
// ---------------------------------------------------------------------------
module tb_tic_tac_toe_game;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       new_game = 1'b0;
    logic       va = 1'b0, vb = 1'b0;
    logic [3:0] pa = 4'd0, pb = 4'd0;

    logic [17:0] bd   [2];
    logic        tn   [2];
    logic        rdy  [2];
    logic        ill  [2];
    logic        ovr  [2];
    logic [1:0]  wnr  [2];
    logic [3:0]  cnt  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tic_tac_toe_game #(.FIRST_PLAYER(1'b1), .POS_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid_A(va), .move_A(pa), .move_valid_B(vb), .move_B(pb),
        .board(bd[0]), .turn(tn[0]), .move_ready(rdy[0]), .illegal_move(ill[0]),
        .game_over(ovr[0]), .winner(wnr[0]), .move_count(cnt[0])
    );

    tic_tac_toe_game #(.FIRST_PLAYER(1'b0), .POS_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .new_game(new_game),
        .move_valid_A(va), .move_A(pa), .move_valid_B(vb), .move_B(pb),
        .board(bd[1]), .turn(tn[1]), .move_ready(rdy[1]), .illegal_move(ill[1]),
        .game_over(ovr[1]), .winner(wnr[1]), .move_count(cnt[1])
    );

    // ---------------- reference model ----------------
    // Cells: 0 empty, 1 A, 2 B. side: 1 = A to move. checking: a move was
    // just placed and its outcome is decided on the next clock.
    int m_cell [2][9];
    bit m_side [2];
    int m_cnt  [2];
    bit m_chk  [2];
    bit m_over [2];
    int m_win  [2];
    bit m_ill  [2];
    bit m_live [2] = '{1'b0, 1'b0};

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [1:0] code_of(input int who);
        if (who == 1) return 2'b01;
        if (who == 2) return 2'b00;
        return 2'b10;
    endfunction

    function automatic bit owns_line(input int m, input int who);
        for (int l = 0; l < 8; l++)
            if (m_cell[m][lines[l][0]] == who && m_cell[m][lines[l][1]] == who &&
                m_cell[m][lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] model_board(input int m);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = code_of(m_cell[m][i]);
        return b;
    endfunction

    task automatic model_step(input int m);
        int  who;
        bit  v;
        int  p;
        if (reset || new_game) begin
            for (int i = 0; i < 9; i++) m_cell[m][i] = 0;
            m_side[m] = (m == 0);
            m_cnt[m]  = 0;
            m_chk[m]  = 1'b0;
            m_over[m] = 1'b0;
            m_win[m]  = 0;
            m_ill[m]  = 1'b0;
            m_live[m] = 1'b1;
            return;
        end
        if (!m_live[m]) return;
        m_ill[m] = 1'b0;
        who = m_side[m] ? 1 : 2;
        if (m_over[m]) begin
            // finished game: nothing changes
        end else if (m_chk[m]) begin
            m_chk[m] = 1'b0;
            if (owns_line(m, who)) begin
                m_over[m] = 1'b1;
                m_win[m]  = who;
            end else if (m_cnt[m] == 9) begin
                m_over[m] = 1'b1;
                m_win[m]  = 0;
            end else begin
                m_side[m] = !m_side[m];
            end
        end else begin
            v = m_side[m] ? va : vb;
            p = m_side[m] ? int'(pa) : int'(pb);
            if (v) begin
                if (p <= 8 && m_cell[m][p] == 0) begin
                    m_cell[m][p] = who;
                    m_cnt[m]     = m_cnt[m] + 1;
                    m_chk[m]     = 1'b1;
                end else begin
                    m_ill[m] = 1'b1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) model_step(m);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (m_live[m]) begin
                check($sformatf("u%0d.board", m),        32'(bd[m]),  32'(model_board(m)));
                check($sformatf("u%0d.turn", m),         32'(tn[m]),  32'(m_side[m]));
                check($sformatf("u%0d.move_ready", m),   32'(rdy[m]), 32'(!m_over[m] && !m_chk[m]));
                check($sformatf("u%0d.illegal_move", m), 32'(ill[m]), 32'(m_ill[m]));
                check($sformatf("u%0d.game_over", m),    32'(ovr[m]), 32'(m_over[m]));
                check($sformatf("u%0d.winner", m),       32'(wnr[m]), 32'(code_of(m_win[m])));
                check($sformatf("u%0d.move_count", m),   32'(cnt[m]), 32'(m_cnt[m]));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Apply inputs for exactly one clock edge, then return everything idle.
    task automatic drive(input bit a_v, input int a_p, input bit b_v, input int b_p,
                         input bit rst = 1'b0, input bit ng = 1'b0);
        va = a_v; pa = 4'(a_p); vb = b_v; pb = 4'(b_p);
        reset = rst; new_game = ng;
        @(negedge clk);
        va = 1'b0; vb = 1'b0; reset = 1'b0; new_game = 1'b0;
    endtask

    // One move plus the CHECK cycle that follows it.
    task automatic move(input bit is_a, input int pos);
        if (is_a) drive(1'b1, pos, 1'b0, 0);
        else      drive(1'b0, 0, 1'b1, pos);
        drive(1'b0, 0, 1'b0, 0);
    endtask

    task automatic play_a_row_win;
        drive(0, 0, 0, 0, 1'b1);
        move(1, 0); move(0, 3); move(1, 1); move(0, 4); move(1, 2);
    endtask

    initial begin
        @(negedge clk);
        // 1: reset state
        drive(0, 0, 0, 0, 1'b1);
        drive(0, 0, 0, 0, 1'b1);
        check("reset.board",  32'(bd[0]), 32'h2AAAA);
        check("reset.turn",   32'(tn[0]), 32'd1);
        check("reset.over",   32'(ovr[0]), 32'd0);
        check("reset.winner", 32'(wnr[0]), 32'd2);
        check("reset.count",  32'(cnt[0]), 32'd0);
        check("reset.turn_b", 32'(tn[1]), 32'd0);

        // 2: A wins along the top row on move five
        play_a_row_win();
        check("win.over",   32'(ovr[0]), 32'd1);
        check("win.winner", 32'(wnr[0]), 32'd1);
        check("win.count",  32'(cnt[0]), 32'd5);
        check("win.board",  32'(bd[0]),  32'h2A815);
        check("win.ready",  32'(rdy[0]), 32'd0);
        // finished game ignores further moves without illegal pulses
        drive(1, 5, 1, 6);
        check("frozen.board",   32'(bd[0]),  32'h2A815);
        check("frozen.illegal", 32'(ill[0]), 32'd0);

        // 6: new_game and reset together clear a finished game
        drive(0, 0, 0, 0, 1'b1, 1'b1);
        check("restart.board",  32'(bd[0]),  32'h2AAAA);
        check("restart.turn",   32'(tn[0]),  32'd1);
        check("restart.turn_b", 32'(tn[1]),  32'd0);
        check("restart.over",   32'(ovr[0]), 32'd0);
        play_a_row_win();
        drive(0, 0, 0, 0, 1'b0, 1'b1);
        check("newgame.board",  32'(bd[0]),  32'h2AAAA);
        check("newgame.winner", 32'(wnr[0]), 32'd2);

        // 3: occupied and out-of-range positions are rejected
        drive(0, 0, 0, 0, 1'b1);
        move(1, 4);
        drive(0, 0, 1, 4);
        check("occupied.illegal", 32'(ill[0]), 32'd1);
        check("occupied.turn",    32'(tn[0]),  32'd0);
        drive(0, 0, 0, 0);
        check("illegal.pulse_end", 32'(ill[0]), 32'd0);
        drive(0, 0, 1, 9);
        check("range.illegal", 32'(ill[0]), 32'd1);
        drive(0, 0, 0, 0);
        check("range.count", 32'(cnt[0]), 32'd1);

        // 4: full board with no line is a draw
        drive(0, 0, 0, 0, 1'b1);
        move(1, 4); move(0, 0); move(1, 2); move(0, 6); move(1, 3);
        move(0, 5); move(1, 1); move(0, 7); move(1, 8);
        check("draw.over",   32'(ovr[0]), 32'd1);
        check("draw.winner", 32'(wnr[0]), 32'd2);
        check("draw.count",  32'(cnt[0]), 32'd9);

        // 5: both valids on A's turn, then valids during CHECK
        drive(0, 0, 0, 0, 1'b1);
        drive(1, 0, 1, 1);
        drive(1, 2, 1, 3);
        check("both.board", 32'(bd[0]),  32'h2AAA9);
        check("both.count", 32'(cnt[0]), 32'd1);
        check("both.turn",  32'(tn[0]),  32'd0);

        // reset during CHECK of a winning move reports nothing
        drive(0, 0, 0, 0, 1'b1);
        move(1, 0); move(0, 3); move(1, 1); move(0, 4);
        drive(1, 2, 0, 0);
        drive(0, 0, 0, 0, 1'b1);
        check("midcheck.over",  32'(ovr[0]), 32'd0);
        check("midcheck.count", 32'(cnt[0]), 32'd0);
        check("midcheck.board", 32'(bd[0]),  32'h2AAAA);

        // randomized play against the model
        for (int c = 0; c < 4000; c++) begin
            va       = 1'($urandom_range(0, 1));
            vb       = 1'($urandom_range(0, 1));
            pa       = 4'($urandom_range(0, 10));
            pb       = 4'($urandom_range(0, 10));
            reset    = ($urandom_range(0, 199) == 0);
            new_game = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        va = 1'b0; vb = 1'b0; reset = 1'b0; new_game = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
